// File: rtl/oc2_regwr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : oc2_regwr_pkg
// Purpose  : Shared widths and types for the register-file write arbiter.
// Revision : 1.0  initial release
// ============================================================================
package oc2_regwr_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } regwr_t;

    typedef enum logic [0:0] {
        NORMAL  = 1'b0,
        STARVED = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/regwr_fifo.sv
`default_nettype none
// ============================================================================
// Module   : regwr_fifo
// Purpose  : In-order queue of long-latency results with a per-slot address
//            match vector covering only live entries.
// Revision : 1.0  initial release
// ============================================================================
module regwr_fifo
    import oc2_regwr_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_push,
    input  regwr_t                           i_push_entry,
    input  logic                             i_pop,
    output regwr_t                           o_head,
    output logic [$clog2(DEPTH+1)-1:0]       o_count,
    output logic                             o_empty,
    output logic                             o_full,
    input  logic [REG_AW-1:0]                i_hz_addr,
    output logic [DEPTH-1:0]                 o_match
);

    localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH+1);

    regwr_t            r_mem [DEPTH];
    logic [c_PW-1:0]   r_wr_ptr;
    logic [c_PW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;
    logic              w_do_push;
    logic              w_do_pop;

    // Explicit wrap so non-power-of-two depths never index past the array.
    function automatic logic [c_PW-1:0] ptr_inc(input logic [c_PW-1:0] p);
        if (p == c_PW'(DEPTH-1))
            return '0;
        else
            return p + c_PW'(1);
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_CW'(DEPTH));
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_push_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A slot is live when its distance from the head is below the count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        int w_off;
        always_comb begin
            if (i >= int'(r_rd_ptr))
                w_off = i - int'(r_rd_ptr);
            else
                w_off = i + DEPTH - int'(r_rd_ptr);
        end
        assign o_match[i] = (w_off < int'(r_count)) && (r_mem[i].addr == i_hz_addr);
    end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Shares the register-file write port between writeback (priority)
//            and queued long-latency results; requests a stall on starvation.
// Revision : 1.0  initial release
// ============================================================================
module regfile_write_arbiter
    import oc2_regwr_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              lu_valid,
    input  logic [REG_AW-1:0] lu_addr,
    input  logic [DATA_W-1:0] lu_data,
    output logic              lu_ready,
    output logic              arb_reg_en,
    output logic [REG_AW-1:0] arb_reg_addr,
    output logic [DATA_W-1:0] arb_reg_data,
    output logic              arb_stall,
    input  logic [REG_AW-1:0] hz_addr,
    output logic              hz_hit
);

    localparam int c_CW = $clog2(DEPTH+1);
    localparam int c_WW = $clog2(MAX_WAIT+1);
    localparam logic [c_WW-1:0] c_WAIT_MAX = c_WW'(MAX_WAIT);

    regwr_t           w_push_entry;
    regwr_t           w_head;
    logic [c_CW-1:0]  w_count;
    logic             w_empty;
    logic             w_full;
    logic [DEPTH-1:0] w_match;
    logic             w_wb_write;
    logic             w_push;
    logic             w_pop;
    logic             w_empty_nxt;
    logic [c_WW-1:0]  r_wait_cnt;
    logic [c_WW-1:0]  w_wait_nxt;
    arb_state_t       r_state;
    arb_state_t       w_state_nxt;

    assign w_wb_write   = wb_en && (wb_addr != '0);
    assign lu_ready     = !w_full && !reset;
    assign w_push       = lu_valid && lu_ready;
    assign w_pop        = !reset && !w_wb_write && !w_empty;
    assign w_push_entry = '{addr: lu_addr, data: lu_data};

    regwr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clock),
        .rst          (reset),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_count      (w_count),
        .o_empty      (w_empty),
        .o_full       (w_full),
        .i_hz_addr    (hz_addr),
        .o_match      (w_match)
    );

    assign hz_hit = (hz_addr != '0) && (|w_match);

    // Zero-destination entries still burn the slot but never reach the file.
    always_ff @(posedge clock) begin
        if (reset) begin
            arb_reg_en   <= 1'b0;
            arb_reg_addr <= '0;
            arb_reg_data <= '0;
        end else if (w_wb_write) begin
            arb_reg_en   <= 1'b1;
            arb_reg_addr <= wb_addr;
            arb_reg_data <= wb_data;
        end else if (!w_empty) begin
            arb_reg_en <= (w_head.addr != '0);
            if (w_head.addr != '0) begin
                arb_reg_addr <= w_head.addr;
                arb_reg_data <= w_head.data;
            end
        end else begin
            arb_reg_en <= 1'b0;
        end
    end

    always_comb begin
        w_wait_nxt = r_wait_cnt;
        if (w_empty || w_pop)
            w_wait_nxt = '0;
        else if (r_wait_cnt != c_WAIT_MAX)
            w_wait_nxt = r_wait_cnt + c_WW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_wait_cnt <= '0;
        else
            r_wait_cnt <= w_wait_nxt;
    end

    assign w_empty_nxt = (w_count == c_CW'(1)) ? (w_pop && !w_push)
                                               : (w_empty && !w_push);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            NORMAL:  if (w_wait_nxt == c_WAIT_MAX) w_state_nxt = STARVED;
            STARVED: if (w_empty_nxt)              w_state_nxt = NORMAL;
            default: w_state_nxt = NORMAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_state <= NORMAL;
        else
            r_state <= w_state_nxt;
    end

    assign arb_stall = (r_state == STARVED);

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Self-checking bench: wb vector table, expected-write scoreboard
//            and directed multi-cycle sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_write_arbiter;
    import oc2_regwr_pkg::*;

    logic        clock;
    logic        reset;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        arb_reg_en;
    logic [4:0]  arb_reg_addr;
    logic [31:0] arb_reg_data;
    logic        arb_stall;
    logic [4:0]  hz_addr;
    logic        hz_hit;

    int total = 0;
    int bad   = 0;

    regwr_t sb[$];

    typedef struct {
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        exp_en;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    regfile_write_arbiter #(
        .DEPTH    (2),
        .MAX_WAIT (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .lu_valid     (lu_valid),
        .lu_addr      (lu_addr),
        .lu_data      (lu_data),
        .lu_ready     (lu_ready),
        .arb_reg_en   (arb_reg_en),
        .arb_reg_addr (arb_reg_addr),
        .arb_reg_data (arb_reg_data),
        .arb_stall    (arb_stall),
        .hz_addr      (hz_addr),
        .hz_hit       (hz_hit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_write(input logic [4:0] a, input logic [31:0] d);
        sb.push_back('{addr: a, data: d});
    endtask

    task automatic wb_busy(input logic [31:0] d);
        wb_en   = 1'b1;
        wb_addr = 5'd3;
        wb_data = d;
        expect_write(5'd3, d);
    endtask

    // Every register-file write must match the next expected write in order.
    always @(negedge clock) begin
        if (arb_reg_en === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got write addr=%0d data=%h, expected none",
                         arb_reg_addr, arb_reg_data);
            end else begin
                regwr_t e;
                e = sb.pop_front();
                check("sb_addr", {27'b0, arb_reg_addr}, {27'b0, e.addr});
                check("sb_data", arb_reg_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 5'd1,  32'h1111_1111, 1'b1, 5'd1,  32'h1111_1111};
        vecs[1] = '{1'b1, 5'd31, 32'hFFFF_0000, 1'b1, 5'd31, 32'hFFFF_0000};
        vecs[2] = '{1'b0, 5'd5,  32'h0000_0055, 1'b0, 5'd31, 32'hFFFF_0000};
        vecs[3] = '{1'b1, 5'd0,  32'h0000_ABCD, 1'b0, 5'd31, 32'hFFFF_0000};
        vecs[4] = '{1'b1, 5'd2,  32'h0000_0000, 1'b1, 5'd2,  32'h0000_0000};
        vecs[5] = '{1'b0, 5'd0,  32'h0000_0000, 1'b0, 5'd2,  32'h0000_0000};

        reset = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        lu_valid = 1'b1; lu_addr = 5'd1; lu_data = 32'h0101_0101; hz_addr = 5'd1;

        // Reset with a pending lu request: nothing may be accepted.
        step();
        step();
        check("rst_ready", lu_ready, 1'b0);
        check("rst_en", arb_reg_en, 1'b0);
        check("rst_stall", arb_stall, 1'b0);
        check("rst_addr", {27'b0, arb_reg_addr}, 32'd0);
        reset = 1'b0;
        lu_valid = 1'b0;
        #1;
        check("rel_ready", lu_ready, 1'b1);
        check("rel_hz_empty", hz_hit, 1'b0);

        for (int i = 0; i < 6; i++) begin
            wb_en   = vecs[i].wb_en;
            wb_addr = vecs[i].wb_addr;
            wb_data = vecs[i].wb_data;
            if (vecs[i].exp_en)
                expect_write(vecs[i].exp_addr, vecs[i].exp_data);
            step();
            check("vec_en", arb_reg_en, vecs[i].exp_en);
            check("vec_addr", {27'b0, arb_reg_addr}, {27'b0, vecs[i].exp_addr});
            check("vec_data", arb_reg_data, vecs[i].exp_data);
        end
        wb_en = 1'b0;

        // Single lu result: two-edge latency, no bypass.
        lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'hDEAD_BEEF;
        expect_write(5'd7, 32'hDEAD_BEEF);
        step();
        lu_valid = 1'b0;
        check("lu_no_bypass", arb_reg_en, 1'b0);
        step();
        check("lu_en", arb_reg_en, 1'b1);
        check("lu_addr", {27'b0, arb_reg_addr}, 32'd7);
        check("lu_data", arb_reg_data, 32'hDEAD_BEEF);
        step();
        check("lu_en_off", arb_reg_en, 1'b0);
        check("lu_addr_hold", {27'b0, arb_reg_addr}, 32'd7);

        // Starvation: wb every cycle holds off addr 9 until the stall kicks in.
        hz_addr = 5'd9;
        lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 32'h0000_0099;
        for (int i = 0; i < 6; i++) begin
            wb_busy(32'h0000_0300 + i);
            step();
            lu_valid = 1'b0;
            check("starve_wb_addr", {27'b0, arb_reg_addr}, 32'd3);
            check("starve_stall", arb_stall, (i >= 4) ? 1'b1 : 1'b0);
            if (i == 0)
                check("starve_hz", hz_hit, 1'b1);
        end
        wb_en = 1'b0;
        expect_write(5'd9, 32'h0000_0099);
        step();
        check("drain_en", arb_reg_en, 1'b1);
        check("drain_addr", {27'b0, arb_reg_addr}, 32'd9);
        check("drain_stall_off", arb_stall, 1'b0);
        check("drain_hz", hz_hit, 1'b0);

        // Full FIFO back-pressure and in-order acceptance after a pop.
        hz_addr = 5'd8;
        wb_busy(32'h0000_0400);
        lu_valid = 1'b1; lu_addr = 5'd5; lu_data = 32'h0000_0555;
        step();
        check("full_ready1", lu_ready, 1'b1);
        wb_busy(32'h0000_0401);
        lu_addr = 5'd6; lu_data = 32'h0000_0666;
        step();
        check("full_ready0", lu_ready, 1'b0);
        wb_busy(32'h0000_0402);
        lu_addr = 5'd8; lu_data = 32'h0000_0888;
        step();
        check("full_held", lu_ready, 1'b0);
        check("full_hz_not_taken", hz_hit, 1'b0);
        check("full_stall", arb_stall, 1'b0);
        wb_en = 1'b0;
        expect_write(5'd5, 32'h0000_0555);
        step();
        check("full_pop5", {27'b0, arb_reg_addr}, 32'd5);
        check("full_ready_back", lu_ready, 1'b1);
        expect_write(5'd6, 32'h0000_0666);
        step();
        lu_valid = 1'b0;
        check("full_pop6", {27'b0, arb_reg_addr}, 32'd6);
        check("full_hz_taken", hz_hit, 1'b1);
        expect_write(5'd8, 32'h0000_0888);
        step();
        check("full_pop8", {27'b0, arb_reg_addr}, 32'd8);
        step();
        check("full_idle", arb_reg_en, 1'b0);

        // wb to r0 frees the slot; lu to r0 is swallowed.
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h0000_0BAD;
        lu_valid = 1'b1; lu_addr = 5'd4; lu_data = 32'h0000_0444;
        expect_write(5'd4, 32'h0000_0444);
        step();
        lu_valid = 1'b0;
        check("r0_push_en", arb_reg_en, 1'b0);
        step();
        check("r0_grant_en", arb_reg_en, 1'b1);
        check("r0_grant_addr", {27'b0, arb_reg_addr}, 32'd4);
        wb_en = 1'b0;
        lu_valid = 1'b1; lu_addr = 5'd0; lu_data = 32'h0000_1234;
        hz_addr = 5'd0;
        step();
        lu_valid = 1'b0;
        check("r0_lu_push_en", arb_reg_en, 1'b0);
        check("r0_lu_hz", hz_hit, 1'b0);
        step();
        check("r0_discard_en", arb_reg_en, 1'b0);
        check("r0_discard_addr", {27'b0, arb_reg_addr}, 32'd4);
        check("r0_discard_data", arb_reg_data, 32'h0000_0444);
        step();
        check("r0_after_en", arb_reg_en, 1'b0);

        // Hazard query against a single queued entry.
        wb_busy(32'h0000_0600);
        lu_valid = 1'b1; lu_addr = 5'd12; lu_data = 32'h0000_0C0C;
        step();
        lu_valid = 1'b0; wb_en = 1'b0;
        hz_addr = 5'd12; #1;
        check("hz_match", hz_hit, 1'b1);
        hz_addr = 5'd13; #1;
        check("hz_other", hz_hit, 1'b0);
        hz_addr = 5'd0; #1;
        check("hz_zero", hz_hit, 1'b0);
        hz_addr = 5'd12;
        expect_write(5'd12, 32'h0000_0C0C);
        step();
        check("hz_pop_addr", {27'b0, arb_reg_addr}, 32'd12);
        check("hz_after_pop", hz_hit, 1'b0);

        // Reset mid-drain drops queued entries.
        wb_busy(32'h0000_0700);
        lu_valid = 1'b1; lu_addr = 5'd20; lu_data = 32'h0000_2020;
        step();
        wb_busy(32'h0000_0701);
        lu_addr = 5'd21; lu_data = 32'h0000_2121;
        step();
        lu_valid = 1'b0; wb_en = 1'b0;
        reset = 1'b1;
        step();
        check("mid_rst_en", arb_reg_en, 1'b0);
        check("mid_rst_ready", lu_ready, 1'b0);
        reset = 1'b0;
        hz_addr = 5'd20; #1;
        check("mid_rst_hz20", hz_hit, 1'b0);
        hz_addr = 5'd21; #1;
        check("mid_rst_hz21", hz_hit, 1'b0);
        check("mid_rst_ready1", lu_ready, 1'b1);
        step();
        step();
        check("mid_rst_idle", arb_reg_en, 1'b0);
        step();

        check("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
